// File: rtl/apb_transfer_sequencer_if.sv
// Bundle of the request/response handshake and APB bus signals for apb_transfer_sequencer.
// master = sequencer view, slave = environment (front end + APB slaves) view.
interface apb_transfer_sequencer_if #(
   parameter int unsigned c_apb_num_slaves = 1
);
   logic                            req_valid;
   logic                            req_ready;
   logic                            req_write;
   logic [31:0]                     req_addr;
   logic [31:0]                     req_wdata;
   logic [3:0]                      req_wstrb;

   logic                            rsp_valid;
   logic                            rsp_ready;
   logic [31:0]                     rsp_rdata;
   logic [1:0]                      rsp_resp;

   logic [31:0]                     PADDR;
   logic                            PWRITE;
   logic [31:0]                     PWDATA;
   logic [3:0]                      PSTRB;
   logic [c_apb_num_slaves-1:0]     PSEL;
   logic                            PENABLE;
   logic [32*c_apb_num_slaves-1:0]  PRDATA;
   logic [c_apb_num_slaves-1:0]     PREADY;
   logic [c_apb_num_slaves-1:0]     PSLVERR;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  PRDATA, PREADY, PSLVERR,
      output req_ready, rsp_valid, rsp_rdata, rsp_resp,
      output PADDR, PWRITE, PWDATA, PSTRB, PSEL, PENABLE
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      output PRDATA, PREADY, PSLVERR,
      input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
      input  PADDR, PWRITE, PWDATA, PSTRB, PSEL, PENABLE
   );
endinterface

// File: rtl/apb_transfer_sequencer.sv
// Single-outstanding APB master: decodes a request to one slave, runs Setup/Access, returns rsp.
// Optional Access-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_transfer_sequencer #(
   parameter int unsigned                    c_apb_num_slaves = 1,
   parameter logic [32*c_apb_num_slaves-1:0] memory_regions1  = '0,
   parameter logic [32*c_apb_num_slaves-1:0] memory_regions2  = (32*c_apb_num_slaves)'(64),
   parameter int unsigned                    c_timeout_cycles = 16
) (
   input logic                   PCLK,
   input logic                   PRESETn,
   apb_transfer_sequencer_if.master bus
);

   localparam int unsigned SW = (c_apb_num_slaves > 1) ? $clog2(c_apb_num_slaves) : 1;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;
   localparam logic [1:0] RespDecErr = 2'b11;

   if (c_apb_num_slaves < 1 || c_apb_num_slaves > 16 || c_timeout_cycles < 1) begin : g_bad_cfg
      $error("apb_transfer_sequencer: unsupported parameter combination");
   end

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e                      state_q, state_d;
   logic [SW-1:0]               sel_q, sel_nxt, dec_idx;
   logic                        dec_hit;
   logic                        req_ready;
   logic                        req_hs;
   logic                        sel_pready, sel_pslverr;
   logic [31:0]                 sel_prdata;
   logic                        tmo_expire;

   logic [31:0]                 paddr_q, paddr_d;
   logic                        pwrite_q, pwrite_d;
   logic [31:0]                 pwdata_q, pwdata_d;
   logic [3:0]                  pstrb_q, pstrb_d;
   logic [c_apb_num_slaves-1:0] psel_q, psel_d;
   logic                        penable_q, penable_d;
   logic                        rsp_valid_q, rsp_valid_d;
   logic [31:0]                 rsp_rdata_q, rsp_rdata_d;
   logic [1:0]                  rsp_resp_q, rsp_resp_d;

   assign req_ready = PRESETn && (state_q == StIdle);
   assign req_hs    = bus.req_valid && req_ready;

   // Lowest matching index wins so overlapping regions still give a one-hot select.
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int i = 0; i < int'(c_apb_num_slaves); i++) begin
         if (!dec_hit && bus.req_addr >= memory_regions1[32*i +: 32]
                      && bus.req_addr <= memory_regions2[32*i +: 32]) begin
            dec_hit = 1'b1;
            dec_idx = SW'(i);
         end
      end
   end

   // Only the selected slave's PREADY/PSLVERR/PRDATA are ever looked at.
   always_comb begin
      sel_pready  = 1'b0;
      sel_pslverr = 1'b0;
      sel_prdata  = '0;
      for (int i = 0; i < int'(c_apb_num_slaves); i++) begin
         if (sel_q == SW'(i)) begin
            sel_pready  = bus.PREADY[i];
            sel_pslverr = bus.PSLVERR[i];
            sel_prdata  = bus.PRDATA[32*i +: 32];
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(c_timeout_cycles + 1);

   logic [TW-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d = tmo_q;
      if (state_q == StSetup) begin
         tmo_d = '0;
      end else if (state_q == StAccess && !sel_pready) begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   // Expires on the not-ready Access cycle that brings the count to the limit.
   assign tmo_expire = (state_q == StAccess) && !sel_pready &&
                       (tmo_q == TW'(c_timeout_cycles - 1));

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   assign tmo_expire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (req_hs) state_d = dec_hit ? StSetup : StResp;
         StSetup:  state_d = StAccess;
         StAccess: if (sel_pready || tmo_expire) state_d = StResp;
         StResp:   if (bus.rsp_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      sel_nxt     = (state_q == StIdle) ? dec_idx : sel_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;

      if (req_hs) begin
         paddr_d  = bus.req_addr;
         pwrite_d = bus.req_write;
         pwdata_d = bus.req_wdata;
         pstrb_d  = bus.req_write ? bus.req_wstrb : 4'h0;
         if (!dec_hit) begin
            rsp_rdata_d = '0;
            rsp_resp_d  = RespDecErr;
         end
      end

      if (state_q == StAccess && state_d == StResp) begin
         if (sel_pready) begin
            rsp_resp_d  = sel_pslverr ? RespSlvErr : RespOkay;
            rsp_rdata_d = (pwrite_q || sel_pslverr) ? 32'h0 : sel_prdata;
         end else begin
            rsp_resp_d  = RespSlvErr;
            rsp_rdata_d = '0;
         end
      end

      for (int i = 0; i < int'(c_apb_num_slaves); i++) begin
         psel_d[i] = (state_d == StSetup || state_d == StAccess) && (sel_nxt == SW'(i));
      end
      penable_d   = (state_d == StAccess);
      rsp_valid_d = (state_d == StResp);
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q     <= StIdle;
         sel_q       <= '0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= RespOkay;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_nxt;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_resp  = rsp_resp_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PWDATA    = pwdata_q;
   assign bus.PSTRB     = pstrb_q;
   assign bus.PSEL      = psel_q;
   assign bus.PENABLE   = penable_q;

endmodule

// File: tb/tb_apb_transfer_sequencer.sv
// Directed-vector bench for apb_transfer_sequencer with two slaves (0x0000-0x0FFF, 0x1000-0x1FFF).
// Build with APB_TIMEOUT_EN defined to also exercise the Access-phase timeout (limit 4).
module tb_apb_transfer_sequencer;

   localparam int unsigned N = 2;

   logic PCLK;
   logic PRESETn;

   apb_transfer_sequencer_if #(.c_apb_num_slaves(N)) bus ();

   apb_transfer_sequencer #(
      .c_apb_num_slaves (N),
      .memory_regions1  ({32'h0000_1000, 32'h0000_0000}),
      .memory_regions2  ({32'h0000_1FFF, 32'h0000_0FFF}),
      .c_timeout_cycles (4)
   ) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   typedef struct {
      string       name;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          wait_n;     // PREADY low Access cycles before it rises
      logic        slverr;
      logic [31:0] prdata;
      int          hold;       // cycles rsp_ready stays low in RESP
      logic [1:0]  exp_psel;
      logic [3:0]  exp_pstrb;
      int          exp_access;
      int          exp_lat;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];
   int   checks;
   int   errors;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endfunction

   task automatic run_vec(input vec_t v);
      int          sel;
      int          acc;
      int          lat;
      logic [1:0]  psel_seen;
      logic        bus_ok;
      logic        resp_idle_ok;
      logic        stable;
      logic [1:0]  r_resp;
      logic [31:0] r_rdata;

      sel = (v.exp_psel == 2'b10) ? 1 : ((v.exp_psel == 2'b01) ? 0 : -1);
      @(posedge PCLK);
      #1;
      bus.req_valid = 1'b1;
      bus.req_write = v.wr;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.wdata;
      bus.req_wstrb = v.wstrb;
      // Unselected slave shows ready+error+junk data, which must be ignored.
      bus.PREADY    = (sel == 1) ? 2'b01 : ((sel == 0) ? 2'b10 : 2'b00);
      bus.PSLVERR   = bus.PREADY;
      bus.PRDATA    = (sel == 1) ? {v.prdata, 32'h0BAD_F00D} : {32'h0BAD_F00D, v.prdata};
      @(negedge PCLK);
      chk({v.name, "_req_ready_idle"}, 32'(bus.req_ready), 32'd1);
      @(posedge PCLK);
      #1;
      bus.req_valid = 1'b0;

      acc = 0; lat = 0; psel_seen = 2'b00; bus_ok = 1'b1; resp_idle_ok = 1'b1;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge PCLK);
         if (bus.PSEL != 2'b00) begin
            psel_seen |= bus.PSEL;
            if (bus.PADDR !== v.addr || bus.PSTRB !== v.exp_pstrb ||
                bus.PWRITE !== v.wr || bus.PWDATA !== v.wdata) bus_ok = 1'b0;
         end
         if (bus.PENABLE) begin
            acc++;
            if (sel >= 0) begin
               bus.PREADY[sel]  = (acc > v.wait_n);
               bus.PSLVERR[sel] = v.slverr && (acc > v.wait_n);
            end
         end
         if (bus.rsp_valid) begin
            lat = k;
            if (bus.PSEL !== 2'b00 || bus.PENABLE !== 1'b0) resp_idle_ok = 1'b0;
         end
      end
      bus.PREADY  = '0;
      bus.PSLVERR = '0;

      chk({v.name, "_latency"},      32'(lat),       32'(v.exp_lat));
      chk({v.name, "_access_cycles"}, 32'(acc),      32'(v.exp_access));
      chk({v.name, "_psel"},         32'(psel_seen), 32'(v.exp_psel));
      chk({v.name, "_apb_stable"},   32'(bus_ok),    32'd1);
      chk({v.name, "_resp_no_psel"}, 32'(resp_idle_ok), 32'd1);
      chk({v.name, "_rsp_resp"},     32'(bus.rsp_resp), 32'(v.exp_resp));
      chk({v.name, "_rsp_rdata"},    bus.rsp_rdata,  v.exp_rdata);
      chk({v.name, "_req_ready_busy"}, 32'(bus.req_ready), 32'd0);

      r_resp = bus.rsp_resp; r_rdata = bus.rsp_rdata; stable = 1'b1;
      for (int h = 0; h < v.hold; h++) begin
         @(negedge PCLK);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_resp !== r_resp || bus.rsp_rdata !== r_rdata ||
             bus.req_ready !== 1'b0) stable = 1'b0;
      end
      if (v.hold > 0) chk({v.name, "_rsp_held"}, 32'(stable), 32'd1);

      bus.rsp_ready = 1'b1;
      @(posedge PCLK);
      #1;
      bus.rsp_ready = 1'b0;
      @(negedge PCLK);
      chk({v.name, "_rsp_valid_after"}, 32'(bus.rsp_valid), 32'd0);
      chk({v.name, "_req_ready_after"}, 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      PRESETn       = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_wstrb = '0;
      bus.rsp_ready = 1'b0;
      bus.PRDATA    = '0;
      bus.PREADY    = '0;
      bus.PSLVERR   = '0;

      //            name       wr    addr          wdata         strb  wt sl prdata        hold psel   pstrb acc lat resp   rdata
      vecs.push_back('{"wr_s1",  1'b1, 32'h0000_1004, 32'hA5A5_A5A5, 4'hF, 0, 1'b0, 32'h0,         0, 2'b10, 4'hF, 1, 3, 2'b00, 32'h0});
      vecs.push_back('{"rd_wait", 1'b0, 32'h0000_0010, 32'h0,        4'hF, 3, 1'b0, 32'hDEAD_BEEF, 0, 2'b01, 4'h0, 4, 6, 2'b00, 32'hDEAD_BEEF});
      vecs.push_back('{"rd_unmap", 1'b0, 32'h0000_2000, 32'h0,       4'h0, 0, 1'b0, 32'h1111_2222, 0, 2'b00, 4'h0, 0, 1, 2'b11, 32'h0});
      vecs.push_back('{"wr_slverr", 1'b1, 32'h0000_0100, 32'h1234_5678, 4'h3, 0, 1'b1, 32'h0,     5, 2'b01, 4'h3, 1, 3, 2'b10, 32'h0});
      vecs.push_back('{"rd_s1_hi", 1'b0, 32'h0000_1FFF, 32'h0,       4'h0, 1, 1'b0, 32'hCAFE_F00D, 0, 2'b10, 4'h0, 2, 4, 2'b00, 32'hCAFE_F00D});
      vecs.push_back('{"rd_s0_err", 1'b0, 32'h0000_0FFF, 32'h0,      4'h0, 0, 1'b1, 32'h7777_7777, 2, 2'b01, 4'h0, 1, 3, 2'b10, 32'h0});
      vecs.push_back('{"rd_top",  1'b0, 32'hFFFF_FFFF, 32'h0,        4'h0, 0, 1'b0, 32'h0,         0, 2'b00, 4'h0, 0, 1, 2'b11, 32'h0});
`ifdef APB_TIMEOUT_EN
      vecs.push_back('{"tmo_stuck", 1'b0, 32'h0000_1040, 32'h0,      4'h0, 100, 1'b0, 32'h5555_AAAA, 0, 2'b10, 4'h0, 4, 6, 2'b10, 32'h0});
      vecs.push_back('{"tmo_race", 1'b0, 32'h0000_1040, 32'h0,       4'h0, 3, 1'b0, 32'h5555_AAAA, 0, 2'b10, 4'h0, 4, 6, 2'b00, 32'h5555_AAAA});
`endif

      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      chk("reset_psel",      32'(bus.PSEL),      32'd0);
      chk("reset_penable",   32'(bus.PENABLE),   32'd0);
      chk("reset_paddr",     bus.PADDR,          32'd0);
      chk("reset_pwrite",    32'(bus.PWRITE),    32'd0);
      chk("reset_pwdata",    bus.PWDATA,         32'd0);
      chk("reset_pstrb",     32'(bus.PSTRB),     32'd0);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_rdata", bus.rsp_rdata,      32'd0);
      chk("reset_rsp_resp",  32'(bus.rsp_resp),  32'd0);
      chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge PCLK);
      #1;
      PRESETn = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset pulse in the middle of an Access phase.
      begin
         int seen_access;
         seen_access = 0;
         @(posedge PCLK);
         #1;
         bus.req_valid = 1'b1;
         bus.req_write = 1'b0;
         bus.req_addr  = 32'h0000_0020;
         bus.PREADY    = '0;
         @(posedge PCLK);
         #1;
         bus.req_valid = 1'b0;
         for (int k = 0; k < 10 && seen_access == 0; k++) begin
            @(negedge PCLK);
            if (bus.PENABLE) seen_access = 1;
         end
         chk("rst_mid_reached_access", 32'(seen_access), 32'd1);
         PRESETn = 1'b0;
         @(posedge PCLK);
         #1;
         PRESETn = 1'b1;
         @(negedge PCLK);
         chk("rst_mid_psel",      32'(bus.PSEL),      32'd0);
         chk("rst_mid_penable",   32'(bus.PENABLE),   32'd0);
         chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("rst_mid_idle",      32'(bus.req_ready), 32'd1);
      end
      run_vec(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/apb_transfer_sequencer.md
# apb_transfer_sequencer

Single-outstanding APB master sequencer on the APB side of the AXI4-Lite-to-APB bridge. Accepts one decoded transfer request from the AXI front end and decodes its address against per-slave regions. Drives the APB Setup/Access phases to the selected slave and returns read data plus an AXI-style response code. It owns the select decode, so PSEL is asserted only during Setup/Access.

## Interface
- c_apb_num_slaves, 1: number of APB slaves (1..16)
- memory_regions1, 0: packed 32*c_apb_num_slaves; slice i = inclusive low address of slave i
- memory_regions2, 64: packed 32*c_apb_num_slaves; slice i = inclusive high address of slave i
- c_timeout_cycles, 16: Access-phase wait limit; used only with APB_TIMEOUT_EN
- PCLK  in  1  sole clock, rising edge
- PRESETn  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  write strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  32  read data (0 for writes and errors)
- rsp_resp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- PADDR  out  32, PWRITE  out  1, PWDATA  out  32, PSTRB  out  4: APB request signals
- PSEL  out  c_apb_num_slaves  one-hot slave select
- PENABLE  out  1  Access-phase marker
- PRDATA  in  32*c_apb_num_slaves  slice i from slave i
- PREADY  in  c_apb_num_slaves, PSLVERR  in  c_apb_num_slaves: per-slave

## Operation
- States: IDLE, SETUP, ACCESS, RESP. Reset (PRESETn=0 at a PCLK edge) → IDLE from any state, including mid-transfer. No transfer is retried.
- Reset values: PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_resp=00. req_ready=0 while PRESETn=0.
- IDLE: req_ready=1. On handshake, capture addr/write/wdata/wstrb. PSTRB captured as 0 for reads. Decode slave i where memory_regions1[i] ≤ addr ≤ memory_regions2[i], unsigned, inclusive.
- Overlapping regions: the lowest index wins, so PSEL stays one-hot.
- Decode hit → SETUP. Miss → RESP with rsp_resp=11; PSEL never asserted.
- SETUP: PSEL[sel]=1, PENABLE=0, one cycle → ACCESS.
- ACCESS: PSEL[sel]=1, PENABLE=1. PADDR/PWRITE/PWDATA/PSTRB are held stable from SETUP until leaving ACCESS.
- On PREADY[sel]=1 → RESP. Capture rsp_rdata = PRDATA slice sel for reads and 0 for writes. Capture rsp_resp = PSLVERR[sel] ? 10 : 00. For a read with PSLVERR, rsp_rdata is forced to 0.
- PREADY/PSLVERR of unselected slaves are ignored.
- RESP: PSEL=0, PENABLE=0, rsp_valid=1. Response held stable until rsp_ready. Handshake → IDLE.
- req_ready=0 in SETUP/ACCESS/RESP. Only one transfer is in flight.

## Timing
- Zero-wait transfer: handshake at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2 → rsp_valid=1 in cycle 3.
- Each PREADY=0 cycle in ACCESS adds one cycle.
- DECERR: handshake at edge 0 → rsp_valid=1 in cycle 1.
- rsp_ready high in the first RESP cycle → IDLE next cycle; the next request can be accepted at that edge.
- Back-to-back zero-wait throughput: one transfer per 4 cycles.
- All outputs are registered except req_ready, which is decoded from state.

## Configuration
- APB_TIMEOUT_EN defined:
  - A counter clears on SETUP→ACCESS and increments each ACCESS cycle with PREADY[sel]=0.
  - When the counter reaches c_timeout_cycles with PREADY[sel] still 0 → RESP, rsp_resp=10, rsp_rdata=0. PSEL/PENABLE drop in the same cycle.
  - PREADY arriving in the same cycle as expiry wins: normal completion.
- APB_TIMEOUT_EN undefined: ACCESS waits indefinitely. No counter logic; c_timeout_cycles is unused.

## Test plan
- 2 slaves, regions 0x0000–0x0FFF and 0x1000–0x1FFF. Write 0x1004 data 0xA5A5A5A5, wstrb 0xF, PREADY=1.
  - Required: PSEL=10, PENABLE 0→1, PSTRB=0xF, rsp_resp=00, rsp_valid in cycle 3.
- Read 0x0010, slave 0 PREADY low for 3 ACCESS cycles, PRDATA=0xDEADBEEF.
  - Required: ACCESS lasts 4 cycles, PADDR stable, rsp_rdata=0xDEADBEEF, rsp_resp=00.
- Read 0x2000 (unmapped).
  - Required: PSEL never asserted, rsp_resp=11, rsp_rdata=0, rsp_valid in cycle 1.
- Write with PSLVERR[0]=1 at PREADY; hold rsp_ready=0 for 5 cycles.
  - Required: rsp_resp=10 held stable, req_ready=0 until rsp handshake.
- PRESETn=0 for one edge during ACCESS.
  - Required: next cycle PSEL=0, PENABLE=0, rsp_valid=0, state IDLE. A new request is then accepted normally.
- APB_TIMEOUT_EN, c_timeout_cycles=4, PREADY stuck 0.
  - Required: rsp_resp=10 after 4 ACCESS cycles. Repeat with PREADY=1 on the expiry cycle → rsp_resp=00.
